// File: rtl/credit_tx.sv
// credit_tx: transmit end of a credit-flow-controlled link
// Accepts a valid/ready stream and sends it as valid-only pulses on a link.
// Ports: clk, rstn (async, active-low)
//        s_valid/s_ready/s_data: upstream valid/ready stream
//        m_valid/m_data: link pulse and payload, one cycle per item
//        m_credit: one credit returned by the far end this cycle
//        credits: current credit count
//        idle: all credits home and nothing on the output register
module credit_tx #(
  parameter type TYPE = logic,
  parameter int CREDITS = 4,
  localparam int CW = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          s_valid,
  output logic          s_ready,
  input  TYPE           s_data,
  output logic          m_valid,
  output TYPE           m_data,
  input  logic          m_credit,
  output logic [CW-1:0] credits,
  output logic          idle
);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);
  if (CREDITS < 1) begin : g_bad_credits
    $fatal(1, "credit_tx: CREDITS must be >= 1");
  end
  logic [CW-1:0] cnt;
  logic fire;
  // s_ready comes from the registered count only; a credit returned while
  // at zero becomes usable one cycle later.
  assign s_ready = cnt != '0;
  assign fire = s_valid && s_ready;
  assign credits = cnt;
  assign idle = (cnt == FULL) && !m_valid;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt <= FULL;
      m_valid <= 1'b0;
    end else begin
      m_valid <= fire;
      // A spurious credit while full is dropped so the count saturates.
      cnt <= (fire && !m_credit) ? cnt - CW'(1) :
             (m_credit && !fire && cnt != FULL) ? cnt + CW'(1) : cnt;
    end
  always_ff @(posedge clk)
    if (fire) m_data <= s_data;
  always_ff @(posedge clk)
    if (rstn)
      assert (!(m_credit && !fire && cnt == FULL))
        else $warning("credit_tx: credit returned with all credits home");
endmodule

// File: doc/credit_tx.md
Name: credit_tx

Overview:
- Transmit end of a credit-flow-controlled link.
- Accepts a valid/ready stream from local logic and forwards it as valid-only pulses across a link that cannot carry backpressure.
- Holds one credit per free entry in the far-end receive buffer; the far-end fifo returns a credit on each entry it drains.
- Placed at the source side of long or pipelined interconnect, so ready never has to cross the link.

Parameters:
- TYPE, logic, payload type.
- CREDITS, 4, capacity of the far-end receive buffer; must be >= 1 (static elaboration check, fatal).
- CW, $clog2(CREDITS+1), width of the credit counter (derived, not overridden).

Ports:
- clk  in  1  clock
- rstn  in  1  reset; rstn, asynchronous, active-low; clock clk
- s_valid  in  1  upstream item valid
- s_ready  out  1  upstream may transfer (a credit is available)
- s_data  in  TYPE  upstream payload
- m_valid  out  1  link pulse; one cycle per forwarded item
- m_data  out  TYPE  link payload, meaningful only when m_valid=1
- m_credit  in  1  one credit returned this cycle (far end freed one entry)
- credits  out  CW  current credit count
- idle  out  1  all credits home and nothing in flight on the output register

Behaviour:
- State:
  - credit counter cnt (CW bits), reset value CREDITS.
  - Output register m_valid/m_data.
- Reset values:
  - cnt=CREDITS, m_valid=0, s_ready=1, credits=CREDITS, idle=1.
  - m_data is not reset; it is don't-care while m_valid=0.
- Handshake:
  - s_ready = (cnt != 0).
  - s_ready is a function of registered state only. There is no combinational path from s_valid or m_credit to s_ready.
  - Transfer (fire) = s_valid && s_ready.
- Latency:
  - On fire in cycle N: m_valid=1 and m_data=s_data in cycle N+1.
  - Without fire: m_valid=0 next cycle and m_data holds its value.
  - m_valid is a single-cycle pulse per item; back-to-back fires give consecutive pulses (throughput 1/cycle while credits last).
- Counter update:
  - fire only: cnt-1.
  - m_credit only: cnt+1.
  - Both in the same cycle: cnt unchanged.
  - Neither: unchanged.
- Zero-credit boundary:
  - With cnt=0, s_ready=0 even if m_credit=1 in the same cycle.
  - The returned credit becomes usable the following cycle (one bubble, accepted for timing).
- Overflow guard:
  - m_credit=1 while cnt==CREDITS and no fire is a protocol error.
  - The simulation assertion fires, and cnt saturates at CREDITS in synthesis.
- Underflow: impossible by construction, since fire requires cnt != 0.
- Outputs:
  - credits = cnt.
  - idle = (cnt==CREDITS) && !m_valid.
- Data integrity:
  - Items leave in acceptance order; none are dropped or duplicated.
  - The total number of outstanding items never exceeds CREDITS.
- Reset mid-operation:
  - Asynchronous reset clears m_valid immediately and restores cnt=CREDITS.
  - Items in flight on the link are discarded.
  - The far-end receiver must be reset in the same domain event; credits returned after reset for pre-reset items are protocol errors.
- CREDITS=1: counter is 1 bit; s_ready alternates with credit return; no special-case logic beyond the width.

Test Plan:
- Reset, CREDITS=4, s_valid=0 -> s_ready=1, credits=4, idle=1, m_valid=0.
- s_valid=1 for 6 cycles with data 0x10..0x15, no m_credit:
  - s_ready drops after 4 fires.
  - m_valid pulses cycles 1-4 carrying 0x10..0x13; credits=0.
  - 0x14 is held upstream.
- From credits=0, pulse m_credit once with s_valid=1 -> s_ready stays 0 that cycle, is 1 next cycle; 0x14 fires, m_valid pulses one cycle later with 0x14, credits back to 0.
- credits=2, fire and m_credit in the same cycle for 10 consecutive cycles -> credits stays 2; 10 consecutive m_valid pulses in order.
- credits=4, assert m_credit -> assertion fires; credits remains 4.
- Mid-stream (credits=1, m_valid=1), drop rstn asynchronously -> m_valid=0 immediately, credits=4, idle=1 after release.
- Random s_valid plus a far-end fifo model draining randomly with 3-cycle credit-return delay -> scoreboard order match, no overflow, outstanding never exceeds 4.
